hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
Scoreboard-based hazard and issue controller for the in-order pipeline (fetch, decode, data-management/register-read, ALU, writeback).
- Tracks destination registers of in-flight instructions between issue from decode and ALU writeback.
- Holds pc and the fetch/decode register on read-after-write hazards, and injects bubbles into the decode/data-management register.
- Provides a drain handshake so software/debug logic can quiesce the pipeline.

Parameters:
REG_ADDRESS_SIZE, 5, register index width
NUM_REGS, 32, architectural registers tracked (2**REG_ADDRESS_SIZE)
MAX_INFLIGHT, 3, maximum outstanding writes per register; counter width = clog2(MAX_INFLIGHT+1)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
d_valid  in  1  decode stage holds a valid instruction
d_r1  in  REG_ADDRESS_SIZE  source register 1
d_r2  in  REG_ADDRESS_SIZE  source register 2
d_use_r2  in  1  instruction reads r2 (low when the immediate is used)
d_rd  in  REG_ADDRESS_SIZE  destination register
d_we  in  1  instruction writes d_rd
wb_valid  in  1  writeback commits this cycle
wb_rd  in  REG_ADDRESS_SIZE  writeback destination
drain_req  in  1  level request to quiesce the pipeline
stall  out  1  hold pc and fetch/decode register
bubble  out  1  force the decode/data-management register to NOP (We=0)
issue  out  1  decode instruction advances this cycle
drained  out  1  pipeline empty and issue halted
busy  out  NUM_REGS  bit i = register i has count>0
sb_error  out  1  sticky: writeback to register with count 0
stall_cycles  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
Reset (reset=0, async):
- All counters 0, state RUN, sb_error 0.
- stall, bubble, issue, drained forced 0; busy 0; stall_cycles 0.

Register 0:
- Never tracked; busy[0] is always 0.
- Reads of r0 never hazard; writes to r0 never increment.

Hazard (combinational, from registered counters only):
- raw = d_valid & (busy[d_r1] | (d_use_r2 & busy[d_r2])).
- waw_full = d_valid & d_we & (d_rd!=0) & (count[d_rd]==MAX_INFLIGHT).
- block = raw | waw_full | (state!=RUN).

Outputs:
- stall = bubble = d_valid & block.
- issue = d_valid & ~block.

Writeback:
- Same-cycle writeback does NOT clear a hazard.
- Counter decrements at the clock edge, so a stalled consumer issues the cycle after wb_valid.

Counter update per register i at posedge:
- +1 if issue & d_we & d_rd==i & i!=0.
- -1 if wb_valid & wb_rd==i & i!=0.
- Both events on the same register: unchanged.
- Decrement at 0: count stays 0, sb_error set (cleared only by reset).

FSM (states RUN, DRAIN, HALTED):
- RUN -> DRAIN when drain_req=1.
- DRAIN -> HALTED when all counters are 0 (evaluated after this cycle's update).
- DRAIN -> RUN if drain_req drops first.
- HALTED -> RUN when drain_req=0.
- drained = (state==HALTED).
- In DRAIN/HALTED, writebacks still decrement counters.

Latency:
- Hazard detected in the same cycle as decode.
- Minimum stall for a back-to-back dependency = writeback distance (3 cycles with the current depth).

Optional Feature:
Macro: HAZARD_CONTROLLER_STALL_COUNT_EN.
- Defined: stall_cycles increments each cycle stall=1, saturates at 32'hFFFFFFFF, resets to 0.
- Undefined: stall_cycles tied to 0 and no counter logic is synthesised.

Decomposition:
Package hazard_controller_pkg holds:
- REG_ADDRESS_SIZE, NUM_REGS and MAX_INFLIGHT defaults.
- FSM state enum {RUN, DRAIN, HALTED}.

Sub-module sb_counter:
- Per-register up/down counter with async active-low reset and underflow flag.
- Instantiated NUM_REGS-1 times (r1..r31).

Test Plan:
1. Issue "r3 = r1+r2" (d_we, rd=3), then the next cycle decode reads r3 -> stall=bubble=1, issue=0 until the cycle after wb_valid with wb_rd=3; then issue=1, busy[3]=0.
2. Decode with d_use_r2=0 and d_r2=3 while busy[3]=1, d_r1=4 not busy -> stall=0, issue=1.
3. Three back-to-back writes to r5 with no writeback -> count=3; a fourth write to r5 -> stall=1 (waw_full); one wb to r5 -> fourth issues next cycle.
4. Same-cycle issue to r6 and wb_rd=6 with count[6]=1 -> count stays 1, busy[6]=1.
5. wb_valid with wb_rd=7 while count[7]=0 -> sb_error=1 sticky; wb_rd=0 -> no effect, sb_error unchanged.
6. drain_req=1 with 2 writes outstanding -> issue=0 immediately, drained=1 one cycle after the last wb; drop drain_req -> RUN next cycle; assert reset mid-DRAIN -> all outputs 0, state RUN.

Source files
------------

// File: rtl/hazard_controller_pkg.sv
// Shared defaults and types for the scoreboard hazard controller.
// Optional feature macro used by the top: HAZARD_CONTROLLER_STALL_COUNT_EN.
package hazard_controller_pkg;

    localparam int unsigned HC_REG_ADDRESS_SIZE = 5;
    localparam int unsigned HC_NUM_REGS         = 1 << HC_REG_ADDRESS_SIZE;
    localparam int unsigned HC_MAX_INFLIGHT     = 3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hc_state_t;

endpackage : hazard_controller_pkg

// File: rtl/sb_counter.sv
// Per-register outstanding-write counter for the scoreboard.
// Ports:
//   clk, rst_n     - clock, async active-low reset
//   inc, dec       - issue of a write / writeback to this register
//   count          - registered outstanding-write count
//   count_next_c   - combinational value count takes at the next edge
//   underflow_c    - combinational: decrement requested while count is 0
module sb_counter #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned MAX   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next_c,
    output logic             underflow_c
);

    // Next-count selection; simultaneous inc and dec cancel out.
    always_comb begin
        count_next_c = count;
        underflow_c  = 1'b0;
        if (inc && !dec) begin
            if (count != WIDTH'(MAX)) begin
                count_next_c = count + WIDTH'(1);
            end
        end else if (dec && !inc) begin
            if (count == '0) begin
                underflow_c = 1'b1;
            end else begin
                count_next_c = count - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next_c;
        end
    end

endmodule : sb_counter

// File: rtl/hazard_controller.sv
// Scoreboard-based hazard / issue controller for the in-order pipeline.
// Tracks outstanding writes per register between issue and writeback, stalls
// decode on RAW hazards or a full per-register counter, and offers a drain
// handshake to quiesce the pipeline.
// Ports:
//   clk, reset            - clock, async active-low reset
//   d_valid/d_r1/d_r2/d_use_r2/d_rd/d_we - decode-stage instruction
//   wb_valid/wb_rd        - writeback commit
//   drain_req             - level request to quiesce
//   stall/bubble/issue    - combinational decode control
//   drained               - pipeline empty and issue halted
//   busy                  - per-register outstanding-write flags (bit 0 always 0)
//   sb_error              - sticky writeback-to-idle-register flag
//   stall_cycles          - stall-cycle counter
// Optional: define HAZARD_CONTROLLER_STALL_COUNT_EN to build the stall counter;
// otherwise stall_cycles is tied to 0.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int unsigned REG_ADDRESS_SIZE = HC_REG_ADDRESS_SIZE,
    parameter int unsigned NUM_REGS         = HC_NUM_REGS,
    parameter int unsigned MAX_INFLIGHT     = HC_MAX_INFLIGHT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        d_valid,
    input  logic [REG_ADDRESS_SIZE-1:0] d_r1,
    input  logic [REG_ADDRESS_SIZE-1:0] d_r2,
    input  logic                        d_use_r2,
    input  logic [REG_ADDRESS_SIZE-1:0] d_rd,
    input  logic                        d_we,
    input  logic                        wb_valid,
    input  logic [REG_ADDRESS_SIZE-1:0] wb_rd,
    input  logic                        drain_req,
    output logic                        stall,
    output logic                        bubble,
    output logic                        issue,
    output logic                        drained,
    output logic [NUM_REGS-1:0]         busy,
    output logic                        sb_error,
    output logic [31:0]                 stall_cycles
);

    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

    hc_state_t state;
    hc_state_t state_next;

    logic [NUM_REGS-1:0][CNT_W-1:0] count;
    logic [NUM_REGS-1:0][CNT_W-1:0] count_next;
    logic [NUM_REGS-1:0]            underflow;

    logic raw;
    logic waw_full;
    logic block;

    // Register 0 is hard-wired: never tracked, never busy.
    assign count[0]      = '0;
    assign count_next[0] = '0;
    assign underflow[0]  = 1'b0;
    assign busy[0]       = 1'b0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
        logic inc;
        logic dec;

        assign inc = issue & d_we & (d_rd == REG_ADDRESS_SIZE'(i));
        assign dec = wb_valid & (wb_rd == REG_ADDRESS_SIZE'(i));

        sb_counter #(
            .WIDTH (CNT_W),
            .MAX   (MAX_INFLIGHT)
        ) u_cnt (
            .clk          (clk),
            .rst_n        (reset),
            .inc          (inc),
            .dec          (dec),
            .count        (count[i]),
            .count_next_c (count_next[i]),
            .underflow_c  (underflow[i])
        );

        assign busy[i] = |count[i];
    end

    // Hazards use registered counters only, so a same-cycle writeback does not
    // release a stalled consumer until the following cycle.
    assign raw      = d_valid & (busy[d_r1] | (d_use_r2 & busy[d_r2]));
    assign waw_full = d_valid & d_we & (d_rd != '0) & (count[d_rd] == CNT_W'(MAX_INFLIGHT));
    assign block    = raw | waw_full | (state != RUN);

    // Decode controls are gated by reset so they read 0 while it is asserted.
    assign stall   = reset & d_valid & block;
    assign bubble  = stall;
    assign issue   = reset & d_valid & ~block;
    assign drained = (state == HALTED);

    // Sticky scoreboard underflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_error <= 1'b0;
        end else if (|underflow) begin
            sb_error <= 1'b1;
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Drain FSM next state; HALTED is judged on post-update counters.
    always_comb begin
        state_next = state;
        unique case (state)
            RUN: begin
                if (drain_req) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!drain_req) begin
                    state_next = RUN;
                end else if (count_next == '0) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                if (!drain_req) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

`ifdef HAZARD_CONTROLLER_STALL_COUNT_EN
    // Saturating count of cycles with stall asserted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    assign stall_cycles = '0;
`endif

endmodule : hazard_controller

// File: tb/tb_hazard_controller.sv
// Directed, table-driven bench for hazard_controller.
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_valid;
    logic [4:0]  d_r1;
    logic [4:0]  d_r2;
    logic        d_use_r2;
    logic [4:0]  d_rd;
    logic        d_we;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        drain_req;
    logic        stall;
    logic        bubble;
    logic        issue;
    logic        drained;
    logic [31:0] busy;
    logic        sb_error;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_pass   = 0;

    hazard_controller dut (
        .clk          (clk),
        .reset        (reset),
        .d_valid      (d_valid),
        .d_r1         (d_r1),
        .d_r2         (d_r2),
        .d_use_r2     (d_use_r2),
        .d_rd         (d_rd),
        .d_we         (d_we),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .drain_req    (drain_req),
        .stall        (stall),
        .bubble       (bubble),
        .issue        (issue),
        .drained      (drained),
        .busy         (busy),
        .sb_error     (sb_error),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    // Reference stall-cycle count for the optional counter build.
    logic [31:0] sc_model;
    always @(posedge clk or negedge reset) begin
        if (!reset) sc_model <= '0;
        else if (stall && sc_model != 32'hFFFF_FFFF) sc_model <= sc_model + 32'd1;
    end

    typedef struct {
        logic        dv;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        u2;
        logic [4:0]  rd;
        logic        we;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        e_stall;
        logic        e_issue;
        logic [31:0] e_busy;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic dv, logic [4:0] r1, logic [4:0] r2, logic u2,
                                logic [4:0] rd, logic we, logic wbv, logic [4:0] wbrd,
                                logic es, logic ei, logic [31:0] eb, logic ee);
        vec_t v;
        v.dv = dv; v.r1 = r1; v.r2 = r2; v.u2 = u2; v.rd = rd; v.we = we;
        v.wbv = wbv; v.wbrd = wbrd; v.e_stall = es; v.e_issue = ei;
        v.e_busy = eb; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic dv, input logic [4:0] rd, input logic we,
                         input logic wbv, input logic [4:0] wbrd, input logic drq);
        d_valid = dv; d_r1 = 5'd0; d_r2 = 5'd0; d_use_r2 = 1'b0;
        d_rd = rd; d_we = we; wb_valid = wbv; wb_rd = wbrd; drain_req = drq;
    endtask

    localparam logic [31:0] B3 = 32'd1 << 3;
    localparam logic [31:0] B5 = 32'd1 << 5;
    localparam logic [31:0] B6 = 32'd1 << 6;
    localparam logic [31:0] B8 = 32'd1 << 8;
    localparam logic [31:0] B9 = 32'd1 << 9;
    localparam logic [31:0] B12 = 32'd1 << 12;
    localparam logic [31:0] B13 = 32'd1 << 13;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // RAW on r3 held until the cycle after its writeback
        vecs.push_back(mk(1, 1, 2, 1, 3, 1, 0, 0, 0, 1, 0,  0));
        vecs.push_back(mk(1, 3, 0, 1, 8, 1, 0, 0, 1, 0, B3, 0));
        vecs.push_back(mk(1, 3, 0, 1, 8, 1, 0, 0, 1, 0, B3, 0));
        vecs.push_back(mk(1, 3, 0, 1, 8, 1, 1, 3, 1, 0, B3, 0));
        vecs.push_back(mk(1, 3, 0, 1, 8, 1, 0, 0, 0, 1, 0,  0));
        // unused r2 slot ignores a busy register
        vecs.push_back(mk(1, 0, 0, 0, 3, 1, 0, 0, 0, 1, B8, 0));
        vecs.push_back(mk(1, 4, 3, 0, 0, 0, 1, 8, 0, 1, B3 | B8, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, B3, 0));
        // write to r0 is not tracked
        vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0,  0));
        // WAW counter fills at three, fourth write waits for a writeback
        vecs.push_back(mk(1, 0, 0, 0, 5, 1, 0, 0, 0, 1, 0,  0));
        vecs.push_back(mk(1, 0, 0, 0, 5, 1, 0, 0, 0, 1, B5, 0));
        vecs.push_back(mk(1, 0, 0, 0, 5, 1, 0, 0, 0, 1, B5, 0));
        vecs.push_back(mk(1, 0, 0, 0, 5, 1, 0, 0, 1, 0, B5, 0));
        vecs.push_back(mk(1, 0, 0, 0, 5, 1, 1, 5, 1, 0, B5, 0));
        vecs.push_back(mk(1, 0, 0, 0, 5, 1, 0, 0, 0, 1, B5, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, B5, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, B5, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, B5, 0));
        // simultaneous issue and writeback to r6 leaves the count at one
        vecs.push_back(mk(1, 0, 0, 0, 6, 1, 0, 0, 0, 1, 0,  0));
        vecs.push_back(mk(1, 0, 0, 0, 6, 1, 1, 6, 0, 1, B6, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, B6, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 6, 0, 0, B6, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0));
        // underflow on r7 is sticky; writeback to r0 has no effect
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1));
        // RAW through r2
        vecs.push_back(mk(1, 0, 0, 0, 9, 1, 0, 0, 0, 1, 0,  1));
        vecs.push_back(mk(1, 0, 9, 1, 0, 0, 0, 0, 1, 0, B9, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, B9, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1));

        // reset state with a valid decode presented
        reset = 1'b1;
        drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_bubble", 32'(bubble), 32'd0);
        chk("rst_issue", 32'(issue), 32'd0);
        chk("rst_drained", 32'(drained), 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_sb_error", 32'(sb_error), 32'd0);
        chk("rst_stall_cycles", stall_cycles, 32'd0);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        reset = 1'b1;
        tick();

        foreach (vecs[i]) begin
            d_valid = vecs[i].dv; d_r1 = vecs[i].r1; d_r2 = vecs[i].r2;
            d_use_r2 = vecs[i].u2; d_rd = vecs[i].rd; d_we = vecs[i].we;
            wb_valid = vecs[i].wbv; wb_rd = vecs[i].wbrd; drain_req = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_bubble", i), 32'(bubble), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_issue", i), 32'(issue), 32'(vecs[i].e_issue));
            chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("v%0d_sb_error", i), 32'(sb_error), 32'(vecs[i].e_err));
            chk($sformatf("v%0d_drained", i), 32'(drained), 32'd0);
            tick();
        end

`ifdef HAZARD_CONTROLLER_STALL_COUNT_EN
        chk("stall_cycles", stall_cycles, sc_model);
`else
        chk("stall_cycles", stall_cycles, 32'd0);
`endif

        // drain with two writes outstanding
        drive(1'b1, 5'd10, 1'b1, 1'b0, 5'd0, 1'b0);
        @(negedge clk); chk("dr_issue_a", 32'(issue), 32'd1); tick();
        drive(1'b1, 5'd11, 1'b1, 1'b0, 5'd0, 1'b0);
        @(negedge clk); chk("dr_issue_b", 32'(issue), 32'd1); tick();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        @(negedge clk); chk("dr_drained_c", 32'(drained), 32'd0); tick();
        drive(1'b1, 5'd12, 1'b1, 1'b1, 5'd10, 1'b1);
        @(negedge clk);
        chk("dr_stall_d", 32'(stall), 32'd1);
        chk("dr_issue_d", 32'(issue), 32'd0);
        chk("dr_drained_d", 32'(drained), 32'd0);
        tick();
        drive(1'b1, 5'd12, 1'b1, 1'b1, 5'd11, 1'b1);
        @(negedge clk);
        chk("dr_issue_e", 32'(issue), 32'd0);
        chk("dr_drained_e", 32'(drained), 32'd0);
        tick();
        drive(1'b1, 5'd12, 1'b1, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("dr_drained_f", 32'(drained), 32'd1);
        chk("dr_issue_f", 32'(issue), 32'd0);
        chk("dr_busy_f", busy, 32'd0);
        tick();
        @(negedge clk);
        chk("dr_drained_g", 32'(drained), 32'd0);
        chk("dr_issue_g", 32'(issue), 32'd1);
        tick();

        // reset while draining
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        @(negedge clk); chk("rd_busy_h", busy, B12); tick();
        drive(1'b1, 5'd13, 1'b1, 1'b0, 5'd0, 1'b1);
        @(negedge clk);
        chk("rd_stall_i", 32'(stall), 32'd1);
        chk("rd_issue_i", 32'(issue), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("rd_rst_stall", 32'(stall), 32'd0);
        chk("rd_rst_bubble", 32'(bubble), 32'd0);
        chk("rd_rst_issue", 32'(issue), 32'd0);
        chk("rd_rst_drained", 32'(drained), 32'd0);
        chk("rd_rst_busy", busy, 32'd0);
        chk("rd_rst_sb_error", 32'(sb_error), 32'd0);
        chk("rd_rst_stall_cycles", stall_cycles, 32'd0);
        tick();
        drain_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rd_run_issue", 32'(issue), 32'd1);
        chk("rd_run_drained", 32'(drained), 32'd0);
        tick();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("rd_run_busy", busy, B13);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_hazard_controller
